// File: rtl/fp_pkg.sv
// Shared floating-point class definitions: one-hot class bit positions and the
// class vector type used by classifiers and the stream wrapper.
package fp_pkg;

   localparam int unsigned NUM_CLASSES = 10;

   localparam int unsigned CLS_NEG_INF  = 0;
   localparam int unsigned CLS_NEG_NORM = 1;
   localparam int unsigned CLS_NEG_DEN  = 2;
   localparam int unsigned CLS_NEG_ZERO = 3;
   localparam int unsigned CLS_POS_ZERO = 4;
   localparam int unsigned CLS_POS_DEN  = 5;
   localparam int unsigned CLS_POS_NORM = 6;
   localparam int unsigned CLS_POS_INF  = 7;
   localparam int unsigned CLS_SNAN     = 8;
   localparam int unsigned CLS_QNAN     = 9;

   typedef logic [NUM_CLASSES-1:0] fp_class_t;

endpackage

// File: rtl/fp_classify_core.sv
// Combinational IEEE-style operand classifier producing a one-hot class vector.
// Parameterised on field widths so other FP units can reuse it.
module fp_classify_core
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W  = 5,
   parameter int unsigned MANT_W = 10
) (
   input  logic [EXP_W+MANT_W:0] operand_i,
   output fp_class_t             class_o
);

   logic              sign;
   logic [EXP_W-1:0]  exp_f;
   logic [MANT_W-1:0] mant_f;
   logic              exp_ones;
   logic              exp_zero;
   logic              mant_zero;

   assign sign      = operand_i[EXP_W+MANT_W];
   assign exp_f     = operand_i[EXP_W+MANT_W-1:MANT_W];
   assign mant_f    = operand_i[MANT_W-1:0];
   assign exp_ones  = &exp_f;
   assign exp_zero  = ~|exp_f;
   assign mant_zero = ~|mant_f;

   always_comb begin
      class_o = '0;
      if (exp_ones && !mant_zero) begin
         // Quiet bit is the mantissa MSB; sign is irrelevant for NaNs.
         if (mant_f[MANT_W-1]) class_o[CLS_QNAN] = 1'b1;
         else                  class_o[CLS_SNAN] = 1'b1;
      end else if (exp_ones) begin
         if (sign) class_o[CLS_NEG_INF] = 1'b1;
         else      class_o[CLS_POS_INF] = 1'b1;
      end else if (exp_zero && mant_zero) begin
         if (sign) class_o[CLS_NEG_ZERO] = 1'b1;
         else      class_o[CLS_POS_ZERO] = 1'b1;
      end else if (exp_zero) begin
         if (sign) class_o[CLS_NEG_DEN] = 1'b1;
         else      class_o[CLS_POS_DEN] = 1'b1;
      end else begin
         if (sign) class_o[CLS_NEG_NORM] = 1'b1;
         else      class_o[CLS_POS_NORM] = 1'b1;
      end
   end

endmodule

// File: rtl/fp_classify_stream.sv
// Streaming FP classifier: one-stage valid/ready register carrying the operand
// and its one-hot class, plus saturating per-class counters and sticky flags.
module fp_classify_stream
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W  = 5,
   parameter int unsigned MANT_W = 10,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MANT_W:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MANT_W:0]  out_data,
   output fp_class_t              out_class,
   input  logic [3:0]             cnt_sel,
   output logic [CNT_W-1:0]       cnt_value,
   input  logic                   cnt_clear,
   output logic                   sticky_nan,
   output logic                   sticky_inf
);

   localparam int unsigned W = 1 + EXP_W + MANT_W;
   localparam logic [3:0] NumClsIdx = 4'(NUM_CLASSES);
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   fp_class_t      in_class;
   logic           accept;

   logic           valid_q, valid_d;
   logic [W-1:0]   data_q, data_d;
   fp_class_t      class_q, class_d;
   logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
   logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
   logic [CNT_W-1:0] cnt_value_q, cnt_value_d;
   logic           sticky_nan_q, sticky_nan_d;
   logic           sticky_inf_q, sticky_inf_d;

   fp_classify_core #(
      .EXP_W  (EXP_W),
      .MANT_W (MANT_W)
   ) u_core (
      .operand_i (in_data),
      .class_o   (in_class)
   );

   // Reset blocks acceptance so nothing slips in while the pipe is being flushed.
   assign in_ready = !rst && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      class_d = class_q;
      if (accept) begin
         valid_d = 1'b1;
         data_d  = in_data;
         class_d = in_class;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clear) begin
            cnt_d[i] = '0;
         end else if (accept && in_class[i] && (cnt_q[i] != CntMax)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      cnt_value_d = (cnt_sel < NumClsIdx) ? cnt_q[cnt_sel] : '0;
      sticky_nan_d = cnt_clear ? 1'b0
                   : (sticky_nan_q || (accept && (in_class[CLS_SNAN] || in_class[CLS_QNAN])));
      sticky_inf_d = cnt_clear ? 1'b0
                   : (sticky_inf_q || (accept && (in_class[CLS_NEG_INF] || in_class[CLS_POS_INF])));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         data_q       <= '0;
         class_q      <= '0;
         cnt_value_q  <= '0;
         sticky_nan_q <= 1'b0;
         sticky_inf_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         class_q      <= class_d;
         cnt_value_q  <= cnt_value_d;
         sticky_nan_q <= sticky_nan_d;
         sticky_inf_q <= sticky_inf_d;
         for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign out_class  = class_q;
   assign cnt_value  = cnt_value_q;
   assign sticky_nan = sticky_nan_q;
   assign sticky_inf = sticky_inf_q;

endmodule

// File: tb/tb_fp_classify_stream.sv
// Bench for fp_classify_stream: default FP16 instance checked every cycle against a
// field-level reference model, plus CNT_W=2 and FP32 instances for directed cases.
module tb_fp_classify_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Default FP16 instance
   logic        v0 = 0, r0, ov0, ordy0 = 1, clr0 = 0, sn0, si0;
   logic [15:0] d0 = 0, od0, cv0;
   logic [9:0]  oc0;
   logic [3:0]  sel0 = 0;

   // CNT_W=2 instance
   logic        v1 = 0, r1, ov1, ordy1 = 1, clr1 = 0, sn1, si1;
   logic [15:0] d1 = 0, od1;
   logic [1:0]  cv1;
   logic [9:0]  oc1;
   logic [3:0]  sel1 = 4;

   // FP32 instance
   logic        v2 = 0, r2, ov2, ordy2 = 1, clr2 = 0, sn2, si2;
   logic [31:0] d2 = 0, od2;
   logic [15:0] cv2;
   logic [9:0]  oc2;
   logic [3:0]  sel2 = 0;

   fp_classify_stream dut0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
      .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .out_class(oc0),
      .cnt_sel(sel0), .cnt_value(cv0), .cnt_clear(clr0),
      .sticky_nan(sn0), .sticky_inf(si0)
   );

   fp_classify_stream #(.CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
      .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .out_class(oc1),
      .cnt_sel(sel1), .cnt_value(cv1), .cnt_clear(clr1),
      .sticky_nan(sn1), .sticky_inf(si1)
   );

   fp_classify_stream #(.EXP_W(8), .MANT_W(23)) dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
      .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .out_class(oc2),
      .cnt_sel(sel2), .cnt_value(cv2), .cnt_clear(clr2),
      .sticky_nan(sn2), .sticky_inf(si2)
   );

   // Model state for dut0
   bit          m_valid;
   logic [15:0] m_data;
   logic [9:0]  m_class;
   int          m_cnt [10];
   int          m_cv;
   bit          m_sn, m_si;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Class index straight from the field rules.
   function automatic int ref_class(input longint unsigned d, input int ew, input int mw);
      longint unsigned emax, e, m, s, qbit;
      emax = (64'd1 << ew) - 1;
      e    = (d >> mw) & emax;
      m    = d & ((64'd1 << mw) - 1);
      s    = (d >> (ew + mw)) & 1;
      qbit = 64'd1 << (mw - 1);
      if (e == emax && m != 0) return (m >= qbit) ? 9 : 8;
      if (e == emax)           return (s != 0) ? 0 : 7;
      if (e == 0 && m == 0)    return (s != 0) ? 3 : 4;
      if (e == 0)              return (s != 0) ? 2 : 5;
      return (s != 0) ? 1 : 6;
   endfunction

   function automatic logic [15:0] rand_fp16();
      logic [4:0] e;
      logic [9:0] m;
      case ($urandom_range(0, 3))
         0: e = 5'd0;
         1: e = 5'd31;
         default: e = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 3))
         0: m = 10'd0;
         1: m = 10'h200 | 10'($urandom_range(0, 511));
         default: m = 10'($urandom_range(0, 1023));
      endcase
      return {1'($urandom_range(0, 1)), e, m};
   endfunction

   // One clock of dut0 against the model; inputs must be set before the call.
   task automatic tick0(output bit acc);
      bit rdy;
      int c;
      int nxt_cv;
      #1;
      rdy = !rst && (!m_valid || ordy0);
      chk("in_ready", 32'(r0), 32'(rdy));
      acc    = v0 && rdy;
      c      = ref_class(64'(d0), 5, 10);
      nxt_cv = (sel0 < 10) ? m_cnt[sel0] : 0;
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = 0; m_class = 0; m_cv = 0; m_sn = 0; m_si = 0;
         for (int i = 0; i < 10; i++) m_cnt[i] = 0;
      end else begin
         m_cv = nxt_cv;
         if (acc) begin
            m_valid = 1; m_data = d0; m_class = 10'(1 << c);
         end else if (ordy0) begin
            m_valid = 0;
         end
         if (clr0) begin
            m_sn = 0; m_si = 0;
            for (int i = 0; i < 10; i++) m_cnt[i] = 0;
         end else if (acc) begin
            if (m_cnt[c] < 65535) m_cnt[c]++;
            if (c >= 8) m_sn = 1;
            if (c == 0 || c == 7) m_si = 1;
         end
      end
      #1;
      chk("out_valid", 32'(ov0), 32'(m_valid));
      chk("out_data", 32'(od0), 32'(m_data));
      chk("out_class", 32'(oc0), 32'(m_class));
      chk("cnt_value", 32'(cv0), 32'(m_cv));
      chk("sticky_nan", 32'(sn0), 32'(m_sn));
      chk("sticky_inf", 32'(si0), 32'(m_si));
   endtask

   initial begin : main
      bit acc;
      int idx;
      logic [15:0] vec35 [10];
      logic [15:0] burst [4];
      logic [31:0] vec39 [3];
      logic [31:0] x32;

      vec35 = '{16'hFC00, 16'hBC00, 16'h8001, 16'h8000, 16'h0000,
                16'h0001, 16'h3C00, 16'h7C00, 16'h7C01, 16'h7E00};
      burst = '{16'h3C00, 16'hC000, 16'h0400, 16'h7E00};
      vec39 = '{32'h7F800000, 32'h7FC00000, 32'h00000001};

      // Reset
      rst = 1;
      tick0(acc);
      tick0(acc);
      rst = 0;

      // Every class in order, back to back
      ordy0 = 1;
      for (int i = 0; i < 10; i++) begin
         v0 = 1; d0 = vec35[i];
         tick0(acc);
         chk("class_table", 32'(oc0), 32'(1 << i));
      end
      v0 = 0;
      for (int s = 0; s < 10; s++) begin
         sel0 = 4'(s);
         tick0(acc);
      end
      sel0 = 4'd12;
      tick0(acc);
      tick0(acc);

      // Burst with a 3-cycle downstream stall
      idx = 0;
      for (int k = 0; k < 12; k++) begin
         ordy0 = !(k >= 1 && k <= 3);
         v0 = (idx < 4);
         d0 = (idx < 4) ? burst[idx] : 16'h0;
         tick0(acc);
         if (acc) idx++;
      end
      chk("burst_accepts", 32'(idx), 32'd4);
      v0 = 0; ordy0 = 1;
      tick0(acc);

      // Clear coincident with an accepted +inf
      v0 = 1; d0 = 16'h7C00; clr0 = 1; sel0 = 4'd7;
      tick0(acc);
      chk("clr_inf_class", 32'(oc0), 32'h080);
      chk("clr_sticky_inf", 32'(si0), 32'd0);
      v0 = 0; clr0 = 0;
      tick0(acc);
      chk("clr_cnt7", 32'(cv0), 32'd0);

      // Reset while stalled with a valid result
      v0 = 1; d0 = 16'h3C00; ordy0 = 0;
      tick0(acc);
      v0 = 0;
      tick0(acc);
      rst = 1;
      tick0(acc);
      rst = 0;
      chk("rst_out_valid", 32'(ov0), 32'd0);
      ordy0 = 1; sel0 = 4'd6;
      tick0(acc);
      chk("rst_cnt6", 32'(cv0), 32'd0);
      v0 = 1; d0 = 16'h3C00;
      tick0(acc);
      v0 = 0;
      tick0(acc);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         v0    = ($urandom_range(0, 3) != 0);
         d0    = rand_fp16();
         ordy0 = ($urandom_range(0, 3) != 0);
         sel0  = 4'($urandom_range(0, 15));
         clr0  = ($urandom_range(0, 40) == 0);
         tick0(acc);
      end
      v0 = 0; clr0 = 0; ordy0 = 1;
      tick0(acc);

      // CNT_W=2 saturation with five +zero operands
      v1 = 1; d1 = 16'h0000; sel1 = 4'd4;
      for (int k = 0; k < 5; k++) begin
         tick0(acc);
         chk("sat_class", 32'(oc1), 32'h010);
      end
      v1 = 0;
      tick0(acc);
      chk("sat_cnt", 32'(cv1), 32'd3);
      tick0(acc);
      chk("sat_cnt_hold", 32'(cv1), 32'd3);

      // FP32 instance
      for (int k = 0; k < 3; k++) begin
         v2 = 1; d2 = vec39[k];
         tick0(acc);
         chk("fp32_class", 32'(oc2), 32'(1 << ref_class(64'(vec39[k]), 8, 23)));
         chk("fp32_data", od2, vec39[k]);
      end
      for (int k = 0; k < 20; k++) begin
         x32 = $urandom;
         if (k % 3 == 0) x32[30:23] = 8'hFF;
         if (k % 3 == 1) x32[30:23] = 8'h00;
         d2 = x32;
         tick0(acc);
         chk("fp32_rand", 32'(oc2), 32'(1 << ref_class(64'(x32), 8, 23)));
      end
      v2 = 0;
      tick0(acc);
      chk("fp32_sticky_nan", 32'(sn2), 32'd1);
      chk("fp32_sticky_inf", 32'(si2), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/fp_classify_stream.md
FP_CLASSIFY_STREAM -- requirements
Module: fp_classify_stream

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MANT_W, default 10, mantissa field width; data width W = 1+EXP_W+MANT_W.
REQ-003 SHALL have parameter CNT_W, default 16, per-class counter width.
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, input operand valid.
REQ-007 SHALL have port in_ready, output, 1, input accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data, input, W, operand {sign, exp, mant}.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port out_data, output, W, operand passed through unchanged.
REQ-012 SHALL have port out_class, output, 10, one-hot class.
REQ-013 SHALL have port cnt_sel, input, 4, counter read index.
REQ-014 SHALL have port cnt_value, output, CNT_W, registered count for cnt_sel.
REQ-015 SHALL have port cnt_clear, input, 1, clears all counters and sticky flags.
REQ-016 SHALL have port sticky_nan, output, 1, a NaN has been accepted since the last clear.
REQ-017 SHALL have port sticky_inf, output, 1, an infinity has been accepted since the last clear.

Function
REQ-018 SHALL encode out_class as follows: bit0 -inf, bit1 -normal, bit2 -denormal, bit3 -zero, bit4 +zero, bit5 +denormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN; exactly one bit is set whenever out_valid=1.
REQ-019 SHALL classify on the fields: exp all-ones and mant!=0 is NaN (mant MSB=1 qNaN, else sNaN, sign ignored); exp all-ones and mant==0 is inf; exp==0 and mant==0 is zero; exp==0 and mant!=0 is denormal; otherwise normal.
REQ-020 SHALL register the result in one output stage: latency is 1 cycle from acceptance to out_valid.
REQ-021 SHALL drive in_ready = !out_valid || out_ready (combinational, full-throughput, no bubble).
REQ-022 SHALL hold out_data, out_class and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL clear out_valid after an output handshake when no new input is accepted in the same cycle.
REQ-024 SHALL increment the counter of the classified class by 1 on each input acceptance, at the same edge that loads the output register.
REQ-025 SHALL saturate each counter at 2^CNT_W-1 without wrap.
REQ-026 SHALL, on cnt_clear=1, zero all counters and sticky flags at the next edge; clear wins over a simultaneous increment or sticky set (the operand is still passed through).
REQ-027 SHALL register cnt_value = count[cnt_sel] (1-cycle read latency), reflecting counter values before the same-edge update; cnt_sel >= 10 returns 0.
REQ-028 SHALL set sticky_nan or sticky_inf at the edge of accepting a NaN or inf (either sign) and hold it until a clear.
REQ-029 SHALL NOT let cnt_clear affect the data pipeline or the handshake.

Reset
REQ-030 SHALL, while rst=1 at an edge, set out_valid=0, out_data=0, out_class=0, all counters 0, cnt_value=0, sticky_nan=0, sticky_inf=0.
REQ-031 SHALL discard an in-flight result on reset mid-stream and accept no input while rst=1 (in_ready forced 0).

Structure
REQ-032 SHALL place NUM_CLASSES=10, the class bit-index constants (CLS_NEG_INF..CLS_QNAN) and the class vector typedef in shared package fp_pkg.
REQ-033 SHALL instantiate one combinational sub-module fp_classify_core (parameters EXP_W, MANT_W; inputs operand; output 10-bit one-hot) that is reusable by other FP units.
REQ-034 SHALL be implementable in 120-400 lines of RTL with no memories and no multicycle paths.

Verification
REQ-035 SHALL cover default FP16 inputs 0xFC00, 0xBC00, 0x8001, 0x8000, 0x0000, 0x0001, 0x3C00, 0x7C00, 0x7C01, 0x7E00 -> out_class 1<<0 .. 1<<9 in order, one cycle after each acceptance.
REQ-036 SHALL cover a 4-operand burst with out_ready=0 from cycle 2 for 3 cycles -> in_ready=0 while stalled, first result held stable, no loss or duplicate, order preserved.
REQ-037 SHALL cover CNT_W=2 with five +zero inputs -> cnt_value for cnt_sel=4 reads 3 (saturated).
REQ-038 SHALL cover cnt_clear asserted in the same cycle as an accepted 0x7C00 -> counter 7=0, sticky_inf=0 next cycle, out_class=0x080 still delivered.
REQ-039 SHALL cover EXP_W=8, MANT_W=23 with inputs 0x7F800000, 0x7FC00000, 0x00000001 -> bits 7, 9, 5.
REQ-040 SHALL cover rst pulse while out_valid=1 and stalled -> out_valid=0, counters 0 next cycle, then normal operation.
